// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive tester for a 4-input / 1-output combinational circuit. It walks
//   rows 0..15 on in1..in4 (in1 = MSB). Each row is held SETTLE_CYCLES cycles
//   plus one sample cycle. At the end of the sample cycle dut_out is compared
//   against TRUTH_TABLE[15-row].
//
//   Ports:
//     clk, rst        rising-edge clock, synchronous active-high reset
//     start, abort    begin a sweep (IDLE only) / cancel a sweep and clear results
//     dut_out         output of the circuit under test
//     in1..in4        circuit inputs, registered
//     busy, done      sweep in progress / one-cycle completion pulse
//     row_idx         row currently applied
//     mismatch        bit 15-r set when row r mismatched (MSB-first like TRUTH_TABLE)
//     fail_count      number of mismatching rows (0..16)
//     pass            completed sweep had no mismatches; valid with done
module truth_table_sweeper #(
    parameter logic [15:0] TRUTH_TABLE   = 16'hB8AD,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_out,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        busy,
    output logic        done,
    output logic [3:0]  row_idx,
    output logic [15:0] mismatch,
    output logic [4:0]  fail_count,
    output logic        pass
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [3:0]  row_d;
    logic [3:0]  in_d;
    logic        busy_d, done_d, pass_d;
    logic [15:0] mismatch_d;
    logic [4:0]  fail_d;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        row_d      = row_idx;
        mismatch_d = mismatch;
        fail_d     = fail_count;
        pass_d     = pass;

        case (state)
            IDLE: begin
                row_d = 4'd0;
                if (start) begin
                    mismatch_d = 16'd0;
                    fail_d     = 5'd0;
                    pass_d     = 1'b0;
                    cnt_d      = SETTLE_LOAD;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt - 8'd1;
                // <= rather than == keeps an illegal load of 0 from hanging here.
                if (cnt <= 8'd1)
                    state_d = SAMPLE;
            end
            SAMPLE: begin
                // ~row_idx is 15-row_idx: the table is stored MSB-first.
                if (dut_out != TRUTH_TABLE[~row_idx]) begin
                    mismatch_d = mismatch | (16'h8000 >> row_idx);
                    fail_d     = fail_count + 5'd1;
                end
                if (row_idx == 4'd15) begin
                    // pass must be valid in the same cycle as done, so it is
                    // taken from the count that includes this final sample.
                    pass_d  = (fail_d == 5'd0);
                    row_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    row_d   = row_idx + 4'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                row_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (abort) begin
            state_d    = IDLE;
            cnt_d      = 8'd0;
            row_d      = 4'd0;
            mismatch_d = 16'd0;
            fail_d     = 5'd0;
            pass_d     = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        in_d   = busy_d ? row_d : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= 8'd0;
            row_idx            <= 4'd0;
            {in1, in2, in3, in4} <= 4'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            mismatch           <= 16'd0;
            fail_count         <= 5'd0;
            pass               <= 1'b0;
        end else begin
            state              <= state_d;
            cnt                <= cnt_d;
            row_idx            <= row_d;
            {in1, in2, in3, in4} <= in_d;
            busy               <= busy_d;
            done               <= done_d;
            mismatch           <= mismatch_d;
            fail_count         <= fail_d;
            pass               <= pass_d;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper. Two instances (settle 4 and 1)
// are driven one at a time; a behavioural circuit model (a 16-entry table,
// optionally with a 2-cycle output lag) produces dut_out.
module tb_truth_table_sweeper;

    localparam logic [15:0] TT = 16'hB8AD;

    typedef struct {
        int          sel;
        logic [15:0] mm;
        logic [4:0]  fc;
        logic        ps;
        int          ts;
        int          lat;
        int          s;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, abort, dut_out;
    int   sel;
    logic [15:0] ct;
    logic dly;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];

    logic        a1, a2, a3, a4, b1, b2, b3, b4;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [3:0]  row0, row1;
    logic [15:0] mm0, mm1;
    logic [4:0]  fc0, fc1;
    logic        st0, st1;

    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);

    truth_table_sweeper #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .abort(abort), .dut_out(dut_out),
        .in1(a1), .in2(a2), .in3(a3), .in4(a4), .busy(busy0), .done(done0),
        .row_idx(row0), .mismatch(mm0), .fail_count(fc0), .pass(pass0));

    truth_table_sweeper #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .abort(abort), .dut_out(dut_out),
        .in1(b1), .in2(b2), .in3(b3), .in4(b4), .busy(busy1), .done(done1),
        .row_idx(row1), .mismatch(mm1), .fail_count(fc1), .pass(pass1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // View of whichever instance is under test.
    logic [3:0]  m_in, m_row;
    logic        m_busy, m_done, m_pass;
    logic [15:0] m_mm;
    logic [4:0]  m_fc;
    always_comb begin
        if (sel == 1) begin
            m_in = {b1, b2, b3, b4}; m_row = row1; m_busy = busy1; m_done = done1;
            m_pass = pass1; m_mm = mm1; m_fc = fc1;
        end else begin
            m_in = {a1, a2, a3, a4}; m_row = row0; m_busy = busy0; m_done = done0;
            m_pass = pass0; m_mm = mm0; m_fc = fc0;
        end
    end

    // Circuit model: table lookup on the current inputs, or on the inputs
    // from two cycles ago for the slow-circuit case.
    logic [3:0] h1 = 4'd0, h2 = 4'd0;
    always @(posedge clk) begin
        h1 <= m_in;
        h2 <= h1;
    end
    assign dut_out = ct[4'd15 - (dly ? h2 : m_in)];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected result of a whole sweep from the circuit's behaviour: with a
    // 2-cycle lag and only one settle cycle, each row sees the previous row's
    // response (row 0 sees the idle input 0, i.e. itself).
    function automatic exp_t mk(input int s, input logic [15:0] c, input logic d);
        exp_t e;
        logic [15:0] tt;
        logic [3:0] r4, src4;
        tt = TT;
        e.mm = 16'd0; e.fc = 5'd0; e.sel = 0; e.ts = 0; e.s = s;
        for (int r = 0; r < 16; r++) begin
            r4   = 4'(r);
            src4 = (d && s < 2 && r > 0) ? 4'(r - 1) : r4;
            if (c[4'd15 - src4] != tt[4'd15 - r4]) begin
                e.mm[4'd15 - r4] = 1'b1;
                e.fc = e.fc + 5'd1;
            end
        end
        e.ps  = (e.fc == 5'd0);
        e.lat = 16 * (s + 1) + 1;
        return e;
    endfunction

    // Monitor: checks the walk every cycle and the results on done.
    always @(negedge clk) begin
        exp_t e;
        int   row;
        if (!rst) begin
            if (m_done) begin
                if (sb.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL spurious_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.ts, e.lat);
                    chk("mismatch", int'(m_mm), int'(e.mm));
                    chk("fail_count", int'(m_fc), int'(e.fc));
                    chk("pass", int'(m_pass), int'(e.ps));
                    chk("busy_in_done", int'(m_busy), 0);
                end
            end else if (sb.size() > 0 && cyc > sb[0].ts) begin
                row = (cyc - sb[0].ts - 1) / (sb[0].s + 1);
                chk("busy", int'(m_busy), 1);
                chk("in_row", int'(m_in), row);
                chk("row_idx", int'(m_row), row);
            end else begin
                chk("idle_busy", int'(m_busy), 0);
                chk("idle_in", int'(m_in), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_and_start(input int sl, input logic [15:0] c, input logic d);
        exp_t e;
        sel = sl; ct = c; dly = d;
        e = mk(sl == 1 ? 1 : 4, c, d);
        e.sel = sl;
        e.ts  = cyc;
        sb.push_back(e);
        start = 1'b1;
    endtask

    task automatic sweep(input int sl, input logic [15:0] c, input logic d, input bit hold);
        int n;
        push_and_start(sl, c, d);
        if (!hold) begin
            tick();
            start = 1'b0;
        end
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            nvec++; nerr++;
            $display("FAIL sweep_timeout: got no done, expected done within 300 cycles");
            sb.delete();
        end
        start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int n;
        bit found;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 0; ct = TT; dly = 1'b0;
        repeat (3) tick();
        chk("rst_in", int'({a1, a2, a3, a4}), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_row", int'(row0), 0);
        chk("rst_mm", int'(mm0), 0);
        chk("rst_fc", int'(fc0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_busy1", int'(busy1), 0);
        rst = 1'b0;
        tick();

        sweep(0, TT, 1'b0, 1'b0);        // golden circuit
        sweep(0, 16'h0000, 1'b0, 1'b0);  // stuck-at-0
        sweep(0, 16'hFFFF, 1'b0, 1'b0);  // stuck-at-1
        sweep(0, TT, 1'b1, 1'b0);        // slow circuit, enough settle time
        for (int i = 0; i < 4; i++)
            sweep(0, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        sweep(0, TT, 1'b0, 1'b1);        // start held through the sweep and DONE

        // start and abort together in IDLE: no sweep
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (6) tick();

        // abort at row 6 of a failing sweep
        push_and_start(0, 16'h0000, 1'b0);
        tick();
        start = 1'b0;
        found = 1'b0; n = 0;
        while (!found && n < 100) begin
            if (row0 == 4'd6 && busy0) found = 1'b1;
            else begin tick(); n++; end
        end
        if (!found) begin
            nvec++; nerr++;
            $display("FAIL abort_row6: got no row 6, expected row 6 within 100 cycles");
        end
        chk("pre_abort_mm_set", int'(mm0 != 16'd0), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        chk("abort_busy", int'(busy0), 0);
        chk("abort_in", int'({a1, a2, a3, a4}), 0);
        chk("abort_mm", int'(mm0), 0);
        chk("abort_fc", int'(fc0), 0);
        chk("abort_pass", int'(pass0), 0);
        chk("abort_done", int'(done0), 0);
        repeat (3) tick();
        sweep(0, TT, 1'b0, 1'b0);

        // reset 40 cycles into a sweep
        push_and_start(0, 16'hFFFF, 1'b0);
        tick();
        start = 1'b0;
        repeat (39) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("midrst_in", int'({a1, a2, a3, a4}), 0);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        chk("midrst_row", int'(row0), 0);
        chk("midrst_mm", int'(mm0), 0);
        chk("midrst_fc", int'(fc0), 0);
        chk("midrst_pass", int'(pass0), 0);
        repeat (3) tick();

        // minimum settle time
        sweep(1, TT, 1'b0, 1'b0);
        sweep(1, TT, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            sweep(1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
